ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: serialises one command byte from the game controller (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) onto the PS2_CLK/PS2_DAT open-collector pair. It runs the request-to-send sequence, drives data bits on device-generated clock edges, checks the device ACK and reports done or error. It sits beside the PS/2 keyboard receiver under main. Top level owns the tristates: line driven low when the matching `_oe` output is 1, released (pulled up) otherwise.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_sync.sv | 41 ++++
 rtl/ps2_host_tx.sv | 153 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and default timings.
// The keyboard receiver imports the same package.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  // 100 us clock inhibit and 15 ms ACK timeout at 50 MHz
  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 750000;
  localparam int PS2_TO_W           = 20;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS2_CLK/PS2_DAT levels with falling-edge strobes.
// Idle lines are high, so the chain resets to 1 to avoid a false edge after reset.
module ps2_line_sync (
  input  logic CLOCK_50,
  input  logic hardRes,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall,
  output logic dat_fall
);

  logic clk_p0, clk_p1, clk_p2;
  logic dat_p0, dat_p1, dat_p2;

  always_ff @(posedge CLOCK_50) begin
    if (hardRes) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
      dat_p2 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk_in;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= ps2_dat_in;
      dat_p1 <= dat_p0;
      dat_p2 <= dat_p1;
    end
  end

  // _p1 is the synchronised level, _p2 its previous value
  assign clk_sync = clk_p1;
  assign dat_sync = dat_p1;
  assign clk_fall = clk_p2 & ~clk_p1;
  assign dat_fall = dat_p2 & ~dat_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-edge frame, ACK check.
// Outputs are open-collector enables; the top level turns them into tristates.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       hardRes,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0]    INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PS2_TO_W-1:0] TO_LAST  = PS2_TO_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t       state, state_n;
  logic [INH_W-1:0]    inh_cnt, inh_cnt_n;
  logic [3:0]          edge_cnt, edge_cnt_n;
  logic [PS2_TO_W-1:0] to_cnt, to_cnt_n;
  logic                clk_oe_n, dat_oe_n, done_n, err_n;
  logic                accept;
  logic [7:0]          byte_q;
  logic                par_q;
  logic                clk_s, dat_s, clk_fall, dat_fall_unused;

  function automatic logic [PS2_TO_W-1:0] sat_inc(input logic [PS2_TO_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ps2_line_sync u_sync (
    .CLOCK_50   (CLOCK_50),
    .hardRes    (hardRes),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_sync   (clk_s),
    .dat_sync   (dat_s),
    .clk_fall   (clk_fall),
    .dat_fall   (dat_fall_unused)
  );

  // Ready is withheld during the done/error pulse so a new command starts one cycle later
  assign cmd_ready = (state == ST_IDLE) && !tx_done && !tx_error;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_n    = state;
    inh_cnt_n  = inh_cnt;
    edge_cnt_n = edge_cnt;
    to_cnt_n   = to_cnt;
    dat_oe_n   = ps2_dat_oe;
    done_n     = 1'b0;
    err_n      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n   = ST_INHIBIT;
          inh_cnt_n = '0;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          state_n  = ST_REQ;
          dat_oe_n = 1'b1;
        end else begin
          inh_cnt_n = inh_cnt + 1'b1;
        end
      end
      ST_REQ: begin
        state_n    = ST_SEND;
        edge_cnt_n = '0;
        to_cnt_n   = '0;
      end
      ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
        to_cnt_n = sat_inc(to_cnt);
        if (to_cnt == TO_LAST) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end else if (state == ST_SEND) begin
          // edge_cnt counts edges already seen: 0-7 data, 8 parity, 9 stop
          if (clk_fall) begin
            edge_cnt_n = edge_cnt + 1'b1;
            if (edge_cnt < 4'd8) begin
              dat_oe_n = ~byte_q[edge_cnt[2:0]];
            end else if (edge_cnt == 4'd8) begin
              dat_oe_n = ~par_q;
            end else begin
              dat_oe_n = 1'b0;
              state_n  = ST_ACK;
            end
          end
        end else if (state == ST_ACK) begin
          if (clk_fall) begin
            if (dat_s) begin
              err_n   = 1'b1;
              state_n = ST_IDLE;
            end else begin
              state_n = ST_WAIT_IDLE;
            end
          end
        end else if (clk_s && dat_s) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n == ST_IDLE) dat_oe_n = 1'b0;
    clk_oe_n = (state_n == ST_INHIBIT) || (state_n == ST_REQ);
  end

  always_ff @(posedge CLOCK_50) begin
    if (hardRes) begin
      state      <= ST_IDLE;
      inh_cnt    <= '0;
      edge_cnt   <= '0;
      to_cnt     <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      state      <= state_n;
      inh_cnt    <= inh_cnt_n;
      edge_cnt   <= edge_cnt_n;
      to_cnt     <= to_cnt_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      busy       <= (state_n != ST_IDLE);
      tx_done    <= done_n;
      tx_error   <= err_n;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (accept) begin
      byte_q <= cmd_data;
      par_q  <= ps2_odd_parity(cmd_data);
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector device model clocks frames back and checks
// the bits seen on the data line against the PS/2 frame format.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 20;
  localparam int TO  = 2000;

  logic       CLOCK_50 = 1'b0;
  logic       hardRes;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready, busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low, dev_dat_low;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50   (CLOCK_50),
    .hardRes    (hardRes),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int compared = 0;
  int mismatched = 0;

  int   cyc = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
  int   rel_cyc = 0, pulse_cyc = -10;
  logic pulse_busy = 1'b1, pulse_ready = 1'b1, ready_next = 1'b0, prev_clk_oe = 1'b0;
  logic [1:0] pulse_oe = 2'b11;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_error === 1'b1) err_cnt++;
    if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) acc_cnt++;
    if (prev_clk_oe === 1'b1 && ps2_clk_oe === 1'b0) rel_cyc = cyc;
    prev_clk_oe = ps2_clk_oe;
    if (cyc == pulse_cyc + 1) ready_next = cmd_ready;
    if (tx_done === 1'b1 || tx_error === 1'b1) begin
      pulse_cyc   = cyc;
      pulse_busy  = busy;
      pulse_ready = cmd_ready;
      pulse_oe    = {ps2_clk_oe, ps2_dat_oe};
    end
  end

  // Reference frame on the wire, index 0 first: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b, input string tag);
    int n, inh;
    cmd_valid = 1'b1;
    cmd_data  = b;
    n = 0;
    while (cmd_ready !== 1'b1 && n < TO * 4) begin
      step();
      n++;
    end
    check({tag, ":ready"}, 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    check({tag, ":busy"}, 32'(busy), 32'd1);
    check({tag, ":ready_low"}, 32'(cmd_ready), 32'd0);
    inh = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && inh < INH + 10) begin
      inh++;
      step();
    end
    check({tag, ":inhibit_len"}, 32'(inh), 32'(INH));
    check({tag, ":req"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'b11);
    step();
    check({tag, ":release"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
  endtask

  // Device: samples the data line while the clock is high, just before each falling edge
  task automatic device(input int n_edges, input logic ack, output logic [10:0] fr);
    int half;
    fr = '0;
    step($urandom_range(40, 10));
    for (int i = 0; i < n_edges; i++) begin
      half = $urandom_range(60, 30);
      step(half);
      fr[i] = ps2_dat_line;
      if (i == 10 && ack) begin
        dev_dat_low = 1'b1;
        step(3);
      end
      dev_clk_low = 1'b1;
      step(half);
      dev_clk_low = 1'b0;
    end
    step(5);
    dev_dat_low = 1'b0;
  endtask

  task automatic finish_checks(input string tag, input logic [7:0] b, input logic [10:0] fr,
                               input logic ack, input int d0, input int e0);
    int n;
    n = 0;
    while (busy === 1'b1 && n < TO * 2) begin
      step();
      n++;
    end
    step(2);
    check({tag, ":idle"}, 32'(busy), 32'd0);
    check({tag, ":frame"}, 32'(fr), 32'(frame_of(b)));
    check({tag, ":done_cnt"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check({tag, ":err_cnt"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    check({tag, ":pulse_busy"}, 32'(pulse_busy), 32'd0);
    check({tag, ":pulse_ready"}, 32'(pulse_ready), 32'd0);
    check({tag, ":ready_next"}, 32'(ready_next), 32'd1);
    check({tag, ":pulse_oe"}, 32'(pulse_oe), 32'd0);
  endtask

  task automatic xfer(input logic [7:0] b, input logic ack, input string tag,
                      output logic [10:0] fr);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(b, tag);
    device(11, ack, fr);
    finish_checks(tag, b, fr, ack, d0, e0);
  endtask

  initial begin
    logic [10:0] fr;
    logic [7:0]  b;
    int d0, e0, a0, n;
    hardRes     = 1'b1;
    cmd_valid   = 1'b0;
    cmd_data    = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    step(3);
    check("rst:clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst:dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(tx_done), 32'd0);
    check("rst:error", 32'(tx_error), 32'd0);
    check("rst:ready", 32'(cmd_ready), 32'd1);
    hardRes = 1'b0;
    step(2);

    xfer(PS2_CMD_SET_LEDS, 1'b1, "ed", fr);
    check("ed:frame_literal", 32'(fr), 32'(11'b1_1_11101101_0));
    xfer(PS2_CMD_ENABLE, 1'b1, "f4", fr);
    check("f4:frame_literal", 32'(fr), 32'(11'b1_0_11110100_0));

    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      xfer(b, 1'b1, "rnd", fr);
    end

    b = 8'($urandom);
    xfer(b, 1'b0, "nack", fr);

    // Device never clocks after release
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(PS2_CMD_ENABLE, "timeout");
    n = 0;
    while (busy === 1'b1 && n < TO + 100) begin
      step();
      n++;
    end
    step(2);
    check("timeout:err_cnt", 32'(err_cnt - e0), 32'd1);
    check("timeout:done_cnt", 32'(done_cnt - d0), 32'd0);
    check("timeout:latency", 32'(pulse_cyc - rel_cyc), 32'(TO));
    check("timeout:pulse_oe", 32'(pulse_oe), 32'd0);
    check("timeout:ready_next", 32'(ready_next), 32'd1);

    // 0xFF offered throughout a 0xED transfer must wait for IDLE
    a0 = acc_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(PS2_CMD_SET_LEDS, "hold_ed");
    cmd_valid = 1'b1;
    cmd_data  = PS2_CMD_RESET;
    device(11, 1'b1, fr);
    check("hold_ed:frame", 32'(fr), 32'(frame_of(PS2_CMD_SET_LEDS)));
    send_cmd(PS2_CMD_RESET, "hold_ff");
    check("hold:accepts", 32'(acc_cnt - a0), 32'd2);
    check("hold_ed:done_cnt", 32'(done_cnt - d0), 32'd1);
    device(11, 1'b1, fr);
    finish_checks("hold_ff", PS2_CMD_RESET, fr, 1'b1, d0 + 1, e0);

    // Reset after the fourth device clock edge
    d0 = done_cnt;
    e0 = err_cnt;
    b  = 8'($urandom);
    send_cmd(b, "midrst");
    device(4, 1'b0, fr);
    check("midrst:partial", 32'(fr[3:0]), 32'(frame_of(b) & 11'h00F));
    hardRes = 1'b1;
    step();
    check("midrst:oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:ready", 32'(cmd_ready), 32'd1);
    hardRes = 1'b0;
    step(100);
    check("midrst:no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst:no_error", 32'(err_cnt - e0), 32'd0);
    xfer(PS2_CMD_RESET, 1'b1, "post_rst", fr);

    check("never_both", 32'(both_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
